// File: rtl/embcpu4k_mem_loader_pkg.sv
// Shared types and constants for the program-memory boot loader.
// Holds the FSM state encoding and the default memory geometry.
package embcpu4k_loader_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int DEF_ADDR_W     = 10;
   localparam int DEF_DEPTH      = 1024;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_COLLECT = 3'd1,
      S_WRITE   = 3'd2,
      S_READ    = 3'd3,
      S_CHECK   = 3'd4,
      S_DONE    = 3'd5
   } state_t;

endpackage

// File: rtl/embcpu4k_mem_loader_if.sv
// Byte-stream input and Avalon-MM program-memory bus of the boot loader.
// master = loader side, slave = stream source / memory side.
interface embcpu4k_mem_loader_if
   import embcpu4k_loader_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
);

   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] mem_address;
   logic [3:0]        mem_byteenable;
   logic              mem_chipselect;
   logic              mem_write;
   logic [31:0]       mem_writedata;
   logic [31:0]       mem_readdata;
   logic              mem_clken;

   modport master (
      input  in_data, in_valid, mem_readdata,
      output in_ready, mem_address, mem_byteenable, mem_chipselect,
             mem_write, mem_writedata, mem_clken
   );

   modport slave (
      output in_data, in_valid, mem_readdata,
      input  in_ready, mem_address, mem_byteenable, mem_chipselect,
             mem_write, mem_writedata, mem_clken
   );

endinterface

// File: rtl/embcpu4k_mem_loader_packer.sv
// Assembles four stream bytes little-endian into one 32-bit word.
// word_valid_o fires on the handshake that delivers the last byte of a word.
module embcpu4k_byte_packer
   import embcpu4k_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clear_i,
   input  logic        en_i,
   input  logic [7:0]  byte_i,
   input  logic        valid_i,
   output logic        ready_o,
   output logic [31:0] word_o,
   output logic        word_valid_o
);

   localparam int IDX_W = $clog2(BYTES_PER_WORD);

   logic [IDX_W-1:0] idx_q, idx_d;
   logic [31:0]      word_q, word_d;
   logic             take;

   assign ready_o      = en_i;
   assign take         = valid_i & en_i;
   assign word_valid_o = take && (idx_q == IDX_W'(BYTES_PER_WORD - 1));
   assign word_o       = word_q;

   always_comb begin
      idx_d  = idx_q;
      word_d = word_q;
      if (clear_i) begin
         idx_d  = '0;
         word_d = '0;
      end else if (take) begin
         // idx wraps naturally back to 0 after the last byte of a word
         word_d[8*idx_q +: 8] = byte_i;
         idx_d                = idx_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx_q  <= '0;
         word_q <= '0;
      end else begin
         idx_q  <= idx_d;
         word_q <= word_d;
      end
   end

endmodule

// File: rtl/embcpu4k_mem_loader.sv
// Boots the on-chip program memory from a byte stream: packs words, writes
// them over Avalon-MM and optionally reads each back to flag corruption.
module embcpu4k_mem_loader
   import embcpu4k_loader_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int VERIFY = 1
)(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [ADDR_W:0]       word_count,
   embcpu4k_mem_loader_if.master bus,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_W-1:0]     err_addr
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   rem_q, rem_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] err_addr_q, err_addr_d;

   logic              pk_clear;
   logic              pk_ready;
   logic [31:0]       pk_word;
   logic              pk_word_valid;

   logic [ADDR_W:0]   count_clamped;
   logic [ADDR_W-1:0] addr_inc;
   logic              advance;

   embcpu4k_byte_packer u_packer (
      .clk          (clk),
      .reset_n      (reset_n),
      .clear_i      (pk_clear),
      .en_i         (state_q == S_COLLECT),
      .byte_i       (bus.in_data),
      .valid_i      (bus.in_valid),
      .ready_o      (pk_ready),
      .word_o       (pk_word),
      .word_valid_o (pk_word_valid)
   );

   assign count_clamped = (word_count > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : word_count;
   // DEPTH need not be a power of two, so wrap explicitly
   assign addr_inc      = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      err_d      = err_q;
      err_addr_d = err_addr_q;
      pk_clear   = 1'b0;
      advance    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               err_d      = 1'b0;
               err_addr_d = '0;
               if (word_count == '0) begin
                  state_d = S_DONE;
               end else begin
                  addr_d   = base_addr;
                  rem_d    = count_clamped;
                  pk_clear = 1'b1;
                  state_d  = S_COLLECT;
               end
            end
         end
         S_COLLECT: if (pk_word_valid) state_d = S_WRITE;
         S_WRITE: begin
            if (VERIFY != 0) state_d = S_READ;
            else             advance = 1'b1;
         end
         S_READ: state_d = S_CHECK;
         S_CHECK: begin
            // only the first mismatch of a load is recorded
            if ((bus.mem_readdata != pk_word) && !err_q) begin
               err_d      = 1'b1;
               err_addr_d = addr_q;
            end
            advance = 1'b1;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (advance) begin
         addr_d  = addr_inc;
         rem_d   = rem_q - (ADDR_W+1)'(1);
         state_d = (rem_q == (ADDR_W+1)'(1)) ? S_DONE : S_COLLECT;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         rem_q      <= '0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
      end
   end

   assign bus.in_ready       = pk_ready;
   assign bus.mem_address    = addr_q;
   assign bus.mem_byteenable = 4'hF;
   assign bus.mem_chipselect = (state_q == S_WRITE) || (state_q == S_READ);
   assign bus.mem_write      = (state_q == S_WRITE);
   assign bus.mem_writedata  = pk_word;
   assign bus.mem_clken      = 1'b1;

   assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done     = (state_q == S_DONE);
   assign error    = err_q;
   assign err_addr = err_addr_q;

endmodule
